// File: rtl/divider_job_issuer_pkg.sv
// Shared types and widths for the divider job issuer: FSM states,
// operand job record and captured result record.
package divider_job_issuer_pkg;

    localparam int DVD_W = 10;
    localparam int DVS_W = 5;
    localparam int Q_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT
    } state_t;

    typedef struct packed {
        logic [DVD_W-1:0] dividend;
        logic [DVS_W-1:0] divisor;
    } job_t;

    typedef struct packed {
        logic [Q_W-1:0]   quo;
        logic [DVS_W-1:0] rem;
        logic             ov;
        logic             dbz;
        logic             to;
    } result_t;

endpackage

// File: rtl/divider_job_issuer_if.sv
// Operand stream, divider side-band and result stream of the job issuer.
// The slave modport is the issuer's view; master is the surrounding system.
interface divider_job_issuer_if;
    import divider_job_issuer_pkg::*;

    logic             InValid;
    logic             InReady;
    logic [DVD_W-1:0] InDividend;
    logic [DVS_W-1:0] InDivisor;

    logic [DVD_W-1:0] Dividend;
    logic [DVS_W-1:0] Divisor;
    logic             Start;
    logic [Q_W-1:0]   Quo;
    logic [DVS_W-1:0] Rem;
    logic             FINISH;
    logic             OV;
    logic             DIVBYZERO;

    logic             OutValid;
    logic             OutReady;
    logic [Q_W-1:0]   OutQuo;
    logic [DVS_W-1:0] OutRem;
    logic             OutOV;
    logic             OutDBZ;
    logic             OutTO;

    modport slave (
        input  InValid, InDividend, InDivisor,
        output InReady,
        output Dividend, Divisor, Start,
        input  Quo, Rem, FINISH, OV, DIVBYZERO,
        output OutValid, OutQuo, OutRem, OutOV, OutDBZ, OutTO,
        input  OutReady
    );

    modport master (
        output InValid, InDividend, InDivisor,
        input  InReady,
        input  Dividend, Divisor, Start,
        output Quo, Rem, FINISH, OV, DIVBYZERO,
        input  OutValid, OutQuo, OutRem, OutOV, OutDBZ, OutTO,
        output OutReady
    );

endinterface

// File: rtl/divider_job_issuer_issue_fifo.sv
// Synchronous operand FIFO, DEPTH entries of one job record each.
// Head entry is presented combinationally; DEPTH must be a power of two.
module issue_fifo
    import divider_job_issuer_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  job_t                    din_i,
    input  logic                    pop_i,
    output job_t                    dout_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    job_t          mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   level_q;
    logic [AW:0]   level_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + 1'b1;
        end else if (do_pop && !do_push) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) begin
            mem_q[wr_q] <= din_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/divider_job_issuer.sv
// Front-end sequencer for the 10/5-bit sequential divider: queues operand
// pairs, issues one job at a time and captures the result for a streaming consumer.
module divider_job_issuer
    import divider_job_issuer_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    divider_job_issuer_if.slave     bus,
    output logic                    Busy,
    output logic [$clog2(DEPTH):0]  Level
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam result_t TO_RES = '{quo: '0, rem: '0, ov: 1'b0, dbz: 1'b0, to: 1'b1};

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic          armed_q;
    logic          start_q;
    job_t          job_q;
    result_t       res_q;
    logic          out_valid_q;

    job_t          in_job;
    job_t          head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          slot_free;
    logic          pop;

    assign in_job    = {bus.InDividend, bus.InDivisor};
    assign slot_free = !out_valid_q || bus.OutReady;
    assign pop       = (state_q == IDLE) && !fifo_empty && slot_free;

    issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (bus.InValid),
        .din_i   (in_job),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (Level)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            armed_q     <= 1'b0;
            start_q     <= 1'b0;
            job_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (out_valid_q && bus.OutReady) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        job_q   <= head;
                        start_q <= 1'b1;
                        state_q <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timer_q <= '0;
                    armed_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    // A FINISH still high from the previous job is ignored until it drops once.
                    if (!bus.FINISH) begin
                        armed_q <= 1'b1;
                    end
                    if (armed_q && bus.FINISH) begin
                        res_q       <= '{quo: bus.Quo, rem: bus.Rem, ov: bus.OV,
                                         dbz: bus.DIVBYZERO, to: 1'b0};
                        out_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        res_q       <= TO_RES;
                        out_valid_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.InReady  = !fifo_full;
    assign bus.Dividend = job_q.dividend;
    assign bus.Divisor  = job_q.divisor;
    assign bus.Start    = start_q;
    assign bus.OutValid = out_valid_q;
    assign bus.OutQuo   = res_q.quo;
    assign bus.OutRem   = res_q.rem;
    assign bus.OutOV    = res_q.ov;
    assign bus.OutDBZ   = res_q.dbz;
    assign bus.OutTO    = res_q.to;
    assign Busy         = (state_q != IDLE);

endmodule
